// File: rtl/led7seg_decode.sv
// Receive-side monitor for a multiplexed 4-digit 7-segment bus: qualifies each digit
// by stability, decodes it to hex + dp and publishes a registered image. Optional
// saturating error-capture counter enabled by LED7SEG_DECODE_ERRCNT_EN.
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | no legal stable run (anode select illegal)
// COUNT | legal sample, counting down to capture
// HELD  | captured; waiting for the sample to change
module led7seg_decode #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  led,
  input  logic [3:0]  sa,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  err,
  output logic        valid,
  output logic        frame
`ifdef LED7SEG_DECODE_ERRCNT_EN
  ,
  output logic [7:0]  errcnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HELD  = 2'd2
  } state_t;

  // Remaining samples needed after the first one of a run.
  localparam logic [7:0] LOAD = 8'(STABLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [11:0] s_q, p_q;
  logic [3:0]  mask_q;
  logic        cap;

  logic [3:0]  s_sa;
  logic [6:0]  s_seg;
  logic        s_dp;
  logic        s_legal;
  logic        s_changed;
  logic [1:0]  s_idx;
  logic [4:0]  dec;
  logic [3:0]  mask_nxt;

  function automatic logic legal_sel(input logic [3:0] sel);
    legal_sel = sel inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
  endfunction

  function automatic logic [1:0] sel_index(input logic [3:0] sel);
    case (sel)
      4'b1110: sel_index = 2'd0;
      4'b1101: sel_index = 2'd1;
      4'b1011: sel_index = 2'd2;
      4'b0111: sel_index = 2'd3;
      default: sel_index = 2'd0;
    endcase
  endfunction

  // Returns {error, nibble}; seg is active-high gfedcba.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'h3F:   decode = 5'h00;
      7'h06:   decode = 5'h01;
      7'h5B:   decode = 5'h02;
      7'h4F:   decode = 5'h03;
      7'h66:   decode = 5'h04;
      7'h6D:   decode = 5'h05;
      7'h7D:   decode = 5'h06;
      7'h07:   decode = 5'h07;
      7'h7F:   decode = 5'h08;
      7'h6F:   decode = 5'h09;
      7'h77:   decode = 5'h0A;
      7'h7C:   decode = 5'h0B;
      7'h39:   decode = 5'h0C;
      7'h5E:   decode = 5'h0D;
      7'h79:   decode = 5'h0E;
      7'h71:   decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  assign s_sa      = s_q[11:8];
  assign s_seg     = ~s_q[6:0];
  assign s_dp      = ~s_q[7];
  assign s_legal   = legal_sel(s_sa);
  assign s_changed = (s_q != p_q);
  assign s_idx     = sel_index(s_sa);
  assign dec       = decode(s_seg);
  assign mask_nxt  = mask_q | (4'b0001 << s_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '1;
      p_q <= '1;
    end else begin
      s_q <= {sa, led};
      p_q <= s_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_legal) begin
          state_d = COUNT;
          cnt_d   = LOAD;
        end
      end
      COUNT: begin
        if (s_changed) begin
          if (s_legal) cnt_d = LOAD;
          else         state_d = IDLE;
        end else if (cnt_q == 8'd1) begin
          cap     = 1'b1;
          state_d = HELD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HELD: begin
        if (s_changed) begin
          if (s_legal) begin
            state_d = COUNT;
            cnt_d   = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits <= '0;
      dp     <= '0;
      err    <= '0;
      valid  <= 1'b0;
      frame  <= 1'b0;
      mask_q <= '0;
    end else begin
      valid <= cap;
      frame <= 1'b0;
      if (cap) begin
        digits[{s_idx, 2'b00} +: 4] <= dec[4] ? 4'h0 : dec[3:0];
        dp[s_idx]  <= s_dp;
        err[s_idx] <= dec[4];
        if (mask_nxt == 4'hF) begin
          frame  <= 1'b1;
          mask_q <= '0;
        end else begin
          mask_q <= mask_nxt;
        end
      end
    end
  end

`ifdef LED7SEG_DECODE_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errcnt <= '0;
    end else if (cap && dec[4] && (errcnt != 8'hFF)) begin
      errcnt <= errcnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_led7seg_decode.sv
// Self-checking bench for led7seg_decode: directed test-plan steps plus random
// scans, compared against a run-length reference model of the bus monitor.
module tb_led7seg_decode;

  localparam int N = 4;

  logic        clk;
  logic        rst_n;
  logic [7:0]  led;
  logic [3:0]  sa;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  err;
  logic        valid;
  logic        frame;
`ifdef LED7SEG_DECODE_ERRCNT_EN
  logic [7:0]  errcnt;
`endif

  led7seg_decode #(.STABLE_CYCLES(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .led    (led),
    .sa     (sa),
    .digits (digits),
    .dp     (dp),
    .err    (err),
    .valid  (valid),
    .frame  (frame)
`ifdef LED7SEG_DECODE_ERRCNT_EN
    ,
    .errcnt (errcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int nvalid = 0;
  int nframe = 0;

  // Active-high gfedcba glyphs for hex 0..F.
  logic [6:0] codes [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: S/P sample pipeline plus a run length of identical legal samples.
  logic [11:0] m_s, m_p;
  int          run;
  logic [15:0] m_digits;
  logic [3:0]  m_dp, m_err, m_mask;
  logic        m_valid, m_frame;
  int          m_errcnt;

  function automatic int zero_count(input logic [3:0] sel);
    int c = 0;
    for (int i = 0; i < 4; i++) if (!sel[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    m_s = '1; m_p = '1; run = 0;
    m_digits = '0; m_dp = '0; m_err = '0; m_mask = '0;
    m_valid = 1'b0; m_frame = 1'b0; m_errcnt = 0;
  endtask

  task automatic model_edge();
    int idx;
    int nib;
    logic [6:0] pat;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_valid = 1'b0;
    m_frame = 1'b0;
    if (zero_count(m_s[11:8]) == 1) run = (m_s == m_p) ? run + 1 : 1;
    else                            run = 0;
    if (run == N) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (!m_s[8+i]) idx = i;
      pat = ~m_s[6:0];
      nib = -1;
      for (int k = 0; k < 16; k++) if (codes[k] == pat) nib = k;
      m_digits[4*idx +: 4] = (nib < 0) ? 4'h0 : 4'(nib);
      m_dp[idx]  = ~m_s[7];
      m_err[idx] = (nib < 0);
      m_valid    = 1'b1;
      m_mask[idx] = 1'b1;
      if (m_mask == 4'hF) begin
        m_frame = 1'b1;
        m_mask  = '0;
      end
      if (nib < 0 && m_errcnt < 255) m_errcnt++;
    end
    if (run > N) run = N + 1;
    m_p = m_s;
    m_s = {sa, led};
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("valid",  {15'd0, valid}, {15'd0, m_valid});
    chk("frame",  {15'd0, frame}, {15'd0, m_frame});
    chk("digits", digits, m_digits);
    chk("dp",     {12'd0, dp},  {12'd0, m_dp});
    chk("err",    {12'd0, err}, {12'd0, m_err});
`ifdef LED7SEG_DECODE_ERRCNT_EN
    chk("errcnt", {8'd0, errcnt}, 16'(m_errcnt));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (valid === 1'b1) nvalid++;
    if (frame === 1'b1) nframe++;
  endtask

  task automatic hold(input logic [3:0] s, input logic [7:0] l, input int n);
    sa  = s;
    led = l;
    repeat (n) step();
  endtask

  // Asserted between edges; outputs must clear without a clock.
  task automatic async_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_digits", digits, 16'h0);
    chk("rst_flags", {8'd0, dp, err}, 16'h0);
    chk("rst_pulses", {14'd0, valid, frame}, 16'h0);
`ifdef LED7SEG_DECODE_ERRCNT_EN
    chk("rst_errcnt", {8'd0, errcnt}, 16'h0);
`endif
    repeat (cycles) step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    sa    = 4'hF;
    led   = 8'hFF;
    model_reset();
    #2;
    async_reset(3);

    // Single digit "1" on digit 0, dp off: capture exactly at E0+N.
    nvalid = 0;
    hold(4'b1110, 8'b1111_1001, N);
    chk("latency_early", 16'(nvalid), 16'd0);
    step();
    chk("latency_at_n", {15'd0, valid}, 16'd1);
    repeat (5) step();
    chk("single_nvalid", 16'(nvalid), 16'd1);
    chk("single_digit0", {12'd0, digits[3:0]}, 16'h1);
    chk("single_dp0", {15'd0, dp[0]}, 16'd0);
    chk("single_err0", {15'd0, err[0]}, 16'd0);

    // Non-hex pattern on digit 1.
    hold(4'b1101, {1'b1, ~7'h49}, 6);
    chk("errpat_err1", {15'd0, err[1]}, 16'd1);
    chk("errpat_digit1", {12'd0, digits[7:4]}, 16'h0);
`ifdef LED7SEG_DECODE_ERRCNT_EN
    chk("errpat_errcnt", {8'd0, errcnt}, 16'd1);
`endif

    // Reset mid-COUNT, then a full run is needed again.
    hold(4'b1011, {1'b1, ~codes[3]}, 2);
    async_reset(2);
    nvalid = 0;
    hold(4'b1011, {1'b1, ~codes[3]}, N);
    chk("post_rst_early", 16'(nvalid), 16'd0);
    step();
    chk("post_rst_capture", {15'd0, valid}, 16'd1);

    // Full frame 2, A, F(dp), 0.
    async_reset(1);
    nvalid = 0; nframe = 0;
    hold(4'b1110, {1'b1, ~codes[2]},  6);
    hold(4'b1101, {1'b1, ~codes[10]}, 6);
    hold(4'b1011, {1'b0, ~codes[15]}, 6);
    hold(4'b0111, {1'b1, ~codes[0]},  6);
    chk("frame_nvalid", 16'(nvalid), 16'd4);
    chk("frame_nframe", 16'(nframe), 16'd1);
    chk("frame_digits", digits, 16'h0FA2);
    chk("frame_dp", {12'd0, dp}, 16'h0004);

    // Glitch rejection and illegal anodes.
    nvalid = 0;
    hold(4'b1110, {1'b1, ~codes[7]}, N - 1);
    hold(4'b1110, {1'b1, ~codes[8]}, 6);
    chk("glitch_nvalid", 16'(nvalid), 16'd1);
    chk("glitch_digit0", {12'd0, digits[3:0]}, 16'h8);
    nvalid = 0;
    hold(4'b1100, {1'b1, ~codes[4]}, 20);
    hold(4'b1111, {1'b1, ~codes[4]}, 20);
    chk("illegal_nvalid", 16'(nvalid), 16'd0);

    // Re-capture after a one-cycle blip.
    nvalid = 0;
    hold(4'b1110, {1'b1, ~codes[5]}, 20);
    chk("hold_once", 16'(nvalid), 16'd1);
    nvalid = 0;
    hold(4'b1110, {1'b1, ~codes[6]}, 1);
    hold(4'b1110, {1'b1, ~codes[5]}, N + 2);
    chk("recapture_nvalid", 16'(nvalid), 16'd1);
    chk("recapture_digit0", {12'd0, digits[3:0]}, 16'h5);

    // Random scans including illegal selects, glitches and error glyphs.
    for (int t = 0; t < 300; t++) begin
      logic [3:0] rs;
      logic [7:0] rl;
      if ($urandom_range(0, 99) < 15) rs = 4'($urandom);
      else                            rs = ~(4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 99) < 70) rl = {1'($urandom), ~codes[$urandom_range(0, 15)]};
      else                            rl = 8'($urandom);
      hold(rs, rl, $urandom_range(1, 8));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
